// File: rtl/urv_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// urv_timer_ctrl_pkg
// Shared definitions for the uRV timer compare/interrupt controller:
//   - register word addresses
//   - CTRL / STATUS bit positions
//   - FSM state encoding
//   - wrap-safe "time has reached compare" helper
// -----------------------------------------------------------------------------
package urv_timer_ctrl_pkg;

    // Register word addresses (address 7 is reserved: reads 0, writes ignored)
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_CMP_LO  = 3'd2;
    localparam logic [2:0] ADDR_CMP_HI  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD  = 3'd4;
    localparam logic [2:0] ADDR_TIME_LO = 3'd5;
    localparam logic [2:0] ADDR_TIME_HI = 3'd6;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // STATUS bit positions
    localparam int STAT_PENDING  = 0;
    localparam int STAT_OVERRUN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_e;

    // Modular "now >= target": the 40-bit difference lies in the lower half of
    // the number circle, i.e. its bit 39 is clear. Stays correct across the
    // 2^40 rollover as long as the two values are less than 2^39 apart.
    function automatic logic time_reached(input logic [39:0] now,
                                          input logic [39:0] target);
        return ((now - target) < 40'h80_0000_0000);
    endfunction

endpackage

// File: rtl/urv_timer_ctrl_regs.sv
// -----------------------------------------------------------------------------
// urv_timer_ctrl_regs
// Bus side of the timer controller: address decode, CTRL/PERIOD storage,
// CMP_LO shadow, TIME_HI snapshot and the registered read-data mux.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   addr, wdata, we, re   CPU register access (single-cycle strobes)
//   time_in               current 40-bit tick count
//   cmp, status           live compare value and STATUS bits (owned by top)
//   rdata                 registered read data, updated only on re
//   periodic, irq_en      CTRL mode bits
//   period                PERIOD reload increment
//   en_set, en_clr        CTRL write with EN=1 / EN=0 (one cycle pulses)
//   commit, commit_val    CMP_HI write and the assembled 40-bit compare value
//   status_clr            write-1-to-clear mask for STATUS
// g_period_width must not exceed the 32-bit data bus.
// -----------------------------------------------------------------------------
module urv_timer_ctrl_regs
    import urv_timer_ctrl_pkg::*;
#(
    parameter int unsigned g_period_width = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                addr,
    input  logic [31:0]               wdata,
    input  logic                      we,
    input  logic                      re,
    input  logic [39:0]               time_in,
    input  logic [39:0]               cmp,
    input  logic [1:0]                status,
    output logic [31:0]               rdata,
    output logic                      periodic,
    output logic                      irq_en,
    output logic [g_period_width-1:0] period,
    output logic                      en_set,
    output logic                      en_clr,
    output logic                      commit,
    output logic [39:0]               commit_val,
    output logic [1:0]                status_clr
);

    logic [2:0]                ctrl_r;
    logic [g_period_width-1:0] period_r;
    logic [31:0]               shadow_r;
    logic [7:0]                snap_r;
    logic [31:0]               rdata_r;
    logic [31:0]               rdata_s;
    logic                      wr_ctrl_s;

    assign wr_ctrl_s  = we && (addr == ADDR_CTRL);
    assign en_set     = wr_ctrl_s && wdata[CTRL_EN];
    assign en_clr     = wr_ctrl_s && !wdata[CTRL_EN];
    assign commit     = we && (addr == ADDR_CMP_HI);
    assign commit_val = {wdata[7:0], shadow_r};
    assign status_clr = (we && (addr == ADDR_STATUS)) ? wdata[1:0] : 2'b00;

    assign periodic   = ctrl_r[CTRL_PERIODIC];
    assign irq_en     = ctrl_r[CTRL_IRQ_EN];
    assign period     = period_r;
    assign rdata      = rdata_r;

    // CPU-writable storage: CTRL, PERIOD, CMP_LO shadow; TIME_HI snapshot on TIME_LO read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r   <= 3'd0;
            period_r <= '0;
            shadow_r <= 32'd0;
            snap_r   <= 8'd0;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_r <= wdata[2:0];
            end
            if (we && (addr == ADDR_PERIOD)) begin
                period_r <= wdata[g_period_width-1:0];
            end
            if (we && (addr == ADDR_CMP_LO)) begin
                shadow_r <= wdata;
            end
            // Latching the upper byte here gives the CPU a coherent 40-bit
            // read even if time_in carries between the two word reads.
            if (re && (addr == ADDR_TIME_LO)) begin
                snap_r <= time_in[39:32];
            end
        end
    end

    // Read-data mux
    always_comb begin
        rdata_s = 32'd0;
        case (addr)
            ADDR_CTRL:    rdata_s = {29'd0, ctrl_r};
            ADDR_STATUS:  rdata_s = {30'd0, status};
            ADDR_CMP_LO:  rdata_s = cmp[31:0];
            ADDR_CMP_HI:  rdata_s = {24'd0, cmp[39:32]};
            ADDR_PERIOD:  rdata_s = 32'(period_r);
            ADDR_TIME_LO: rdata_s = time_in[31:0];
            ADDR_TIME_HI: rdata_s = {24'd0, snap_r};
            default:      rdata_s = 32'd0;
        endcase
    end

    // Read data register: captured on re, held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'd0;
        end else if (re) begin
            rdata_r <= rdata_s;
        end
    end

endmodule

// File: rtl/urv_timer_ctrl.sv
// -----------------------------------------------------------------------------
// urv_timer_ctrl
// Compare/interrupt controller for the uRV system timer. Holds a 40-bit
// compare value and raises a level interrupt when the tick count reaches it,
// in one-shot or auto-reload (periodic) mode.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-low reset
//   time_i   40-bit tick count from the timer
//   tick_i   prescaler tick (compare runs every cycle, so it is not needed)
//   addr_i   register word address
//   data_i   write data
//   we_i     write strobe
//   re_i     read strobe
//   data_o   registered read data, valid the cycle after re_i
//   irq_o    timer interrupt (PENDING & IRQ_EN)
// -----------------------------------------------------------------------------
module urv_timer_ctrl
    import urv_timer_ctrl_pkg::*;
#(
    parameter int unsigned g_period_width = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [39:0] time_i,
    input  logic        tick_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    state_e                    state_r;
    state_e                    state_n;
    logic [39:0]               cmp_r;
    logic [39:0]               cmp_n;
    logic                      pending_r;
    logic                      pending_n;
    logic                      overrun_r;
    logic                      overrun_n;

    logic                      periodic_s;
    logic                      irq_en_s;
    logic [g_period_width-1:0] period_s;
    logic                      en_set_s;
    logic                      en_clr_s;
    logic                      commit_s;
    logic [39:0]               commit_val_s;
    logic [1:0]                status_clr_s;
    logic                      match_s;
    logic                      fire_s;
    logic                      reload_s;
    logic                      tick_unused_s;

    // Comparison is done every cycle, so the prescaler tick carries no information here.
    assign tick_unused_s = tick_i;

    urv_timer_ctrl_regs #(
        .g_period_width (g_period_width)
    ) u_regs (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .addr       (addr_i),
        .wdata      (data_i),
        .we         (we_i),
        .re         (re_i),
        .time_in    (time_i),
        .cmp        (cmp_r),
        .status     ({overrun_r, pending_r}),
        .rdata      (data_o),
        .periodic   (periodic_s),
        .irq_en     (irq_en_s),
        .period     (period_s),
        .en_set     (en_set_s),
        .en_clr     (en_clr_s),
        .commit     (commit_s),
        .commit_val (commit_val_s),
        .status_clr (status_clr_s)
    );

    assign match_s  = time_reached(time_i, cmp_r);
    assign fire_s   = (state_r == ST_ARMED) && match_s;
    assign reload_s = fire_s && periodic_s;

    // A CPU commit always beats the periodic reload; the match itself was
    // already decided against the old cmp this cycle.
    assign cmp_n = commit_s ? commit_val_s :
                   reload_s ? (cmp_r + 40'(period_s)) : cmp_r;

    // New match beats W1C. OVERRUN only when the previous event is still
    // unacknowledged, so a clear racing the match counts as acknowledged.
    assign pending_n = fire_s | (pending_r & ~status_clr_s[STAT_PENDING]);
    assign overrun_n = (fire_s & pending_r & ~status_clr_s[STAT_PENDING]) |
                       (overrun_r & ~status_clr_s[STAT_OVERRUN]);

    assign irq_o = pending_r & irq_en_s;

    // Next-state logic of the compare FSM
    always_comb begin
        state_n = state_r;
        if (en_clr_s) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_set_s) state_n = ST_ARMED;
                    else          state_n = ST_IDLE;
                end
                ST_ARMED: begin
                    if (fire_s && !periodic_s) state_n = ST_FIRED;
                    else                       state_n = ST_ARMED;
                end
                ST_FIRED: begin
                    if (commit_s) state_n = ST_ARMED;
                    else          state_n = ST_FIRED;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, compare value and STATUS registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ST_IDLE;
            cmp_r     <= 40'd0;
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            cmp_r     <= cmp_n;
            pending_r <= pending_n;
            overrun_r <= overrun_n;
        end
    end

endmodule

// File: tb/tb_urv_timer_ctrl.sv
module tb_urv_timer_ctrl;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_CMP_LO  = 3'd2;
    localparam logic [2:0] A_CMP_HI  = 3'd3;
    localparam logic [2:0] A_PERIOD  = 3'd4;
    localparam logic [2:0] A_TIME_LO = 3'd5;
    localparam logic [2:0] A_TIME_HI = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] time_v;
    logic        tick;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    urv_timer_ctrl #(.g_period_width(32)) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .time_i (time_v),
        .tick_i (tick),
        .addr_i (addr),
        .data_i (wdata),
        .we_i   (we),
        .re_i   (re),
        .data_o (rdata),
        .irq_o  (irq)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0; wdata = 32'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        cyc();
        re = 1'b0;
        d = rdata;
    endtask

    task automatic set_cmp(input logic [39:0] c);
        wr(A_CMP_LO, c[31:0]);
        wr(A_CMP_HI, {24'd0, c[39:32]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 32'd0;
        time_v = 40'd0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 32'd0;
        time_v = 40'd0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset data_o got %h exp 0", rdata); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset irq got %b exp 0", irq); end
        rst_n = 1'b1;
        rd(A_CTRL, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset CTRL got %h exp 0", d); end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset STATUS got %h exp 0", d); end
        rd(A_PERIOD, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset PERIOD got %h exp 0", d); end
        rd(A_TIME_HI, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset snapshot got %h exp 0", d); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic        exp;
        do_reset();
        set_cmp(40'd100);
        time_v = 40'd90;
        wr(A_CTRL, 32'h5);
        for (int t = 90; t <= 103; t++) begin
            time_v = 40'(t);
            cyc();
            exp = (t >= 100);
            n_tests++; if (irq !== exp) begin n_fail++; $display("FAIL oneshot irq t=%0d got %b exp %b", t, irq, exp); end
        end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL oneshot STATUS got %h exp 1", d); end
        wr(A_STATUS, 32'h1);
        for (int t = 104; t <= 108; t++) begin
            time_v = 40'(t);
            cyc();
            n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot retrigger t=%0d got %b exp 0", t, irq); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        logic        exp;
        logic        hit;
        do_reset();
        set_cmp(40'd100);
        wr(A_PERIOD, 32'd50);
        time_v = 40'd95;
        wr(A_CTRL, 32'h7);
        for (int t = 95; t <= 305; t++) begin
            time_v = 40'(t);
            cyc();
            hit = (t == 100) || (t == 150) || (t == 200);
            exp = (t >= 250) ? 1'b1 : hit;
            n_tests++; if (irq !== exp) begin n_fail++; $display("FAIL periodic irq t=%0d got %b exp %b", t, irq, exp); end
            if (hit) begin
                wr(A_STATUS, 32'h1);
                n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic clear t=%0d got %b exp 0", t, irq); end
            end
            if (t == 240) begin
                rd(A_STATUS, d);
                n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL periodic no-overrun STATUS got %h exp 0", d); end
            end
        end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL periodic overrun STATUS got %h exp 3", d); end
    endtask

    task automatic test_wrap();
        logic [39:0] t;
        logic        fired;
        logic        hit;
        do_reset();
        set_cmp(40'h00_0000_0005);
        time_v = 40'hFF_FFFF_FFF0;
        wr(A_CTRL, 32'h5);
        fired = 1'b0;
        for (int i = 0; i < 24; i++) begin
            t = 40'hFF_FFFF_FFF0 + 40'(i);
            time_v = t;
            cyc();
            fired = fired | (t == 40'd5);
            n_tests++; if (irq !== fired) begin n_fail++; $display("FAIL wrap oneshot t=%h got %b exp %b", t, irq, fired); end
        end
        do_reset();
        set_cmp(40'hFF_FFFF_FFF0);
        wr(A_PERIOD, 32'h20);
        time_v = 40'hFF_FFFF_FFE8;
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 48; i++) begin
            t = 40'hFF_FFFF_FFE8 + 40'(i);
            time_v = t;
            cyc();
            hit = (t == 40'hFF_FFFF_FFF0) || (t == 40'h00_0000_0010);
            n_tests++; if (irq !== hit) begin n_fail++; $display("FAIL wrap periodic t=%h got %b exp %b", t, irq, hit); end
            if (hit) wr(A_STATUS, 32'h1);
        end
    endtask

    task automatic test_shadow_commit();
        logic exp;
        do_reset();
        time_v = 40'd150;
        wr(A_CTRL, 32'h5);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL past-cmp early got %b exp 0", irq); end
        cyc();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL past-cmp fire got %b exp 1", irq); end
        wr(A_STATUS, 32'h1);
        wr(A_CMP_LO, 32'd200);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL shadow only irq got %b exp 0", irq); end
        end
        wr(A_CMP_HI, 32'd0);
        for (int t = 190; t <= 202; t++) begin
            time_v = 40'(t);
            cyc();
            exp = (t >= 200);
            n_tests++; if (irq !== exp) begin n_fail++; $display("FAIL commit rearm t=%0d got %b exp %b", t, irq, exp); end
        end
    endtask

    task automatic test_commit_collision();
        do_reset();
        set_cmp(40'd100);
        wr(A_PERIOD, 32'd50);
        time_v = 40'd50;
        wr(A_CTRL, 32'h7);
        wr(A_CMP_LO, 32'd300);
        time_v = 40'd100;
        wr(A_CMP_HI, 32'd0);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collision old-cmp match got %b exp 1", irq); end
        wr(A_STATUS, 32'h1);
        time_v = 40'd150;
        cyc();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL collision reload leaked got %b exp 0", irq); end
        time_v = 40'd299;
        cyc();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL collision t=299 got %b exp 0", irq); end
        time_v = 40'd300;
        cyc();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collision t=300 got %b exp 1", irq); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        do_reset();
        set_cmp(40'd100);
        wr(A_PERIOD, 32'd10);
        time_v = 40'd50;
        wr(A_CTRL, 32'h7);
        time_v = 40'd100;
        cyc();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c first match got %b exp 1", irq); end
        time_v = 40'd110;
        wr(A_STATUS, 32'h1);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c set-wins irq got %b exp 1", irq); end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL w1c STATUS got %h exp 1", d); end
    endtask

    task automatic test_period_zero();
        logic [31:0] d;
        do_reset();
        set_cmp(40'd10);
        time_v = 40'd20;
        wr(A_CTRL, 32'h7);
        cyc();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL period0 irq got %b exp 1", irq); end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL period0 first STATUS got %h exp 1", d); end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL period0 second STATUS got %h exp 3", d); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        do_reset();
        time_v = 40'h12_0000_ABCD;
        rd(A_TIME_LO, d);
        n_tests++; if (d !== 32'h0000_ABCD) begin n_fail++; $display("FAIL TIME_LO got %h exp 0000abcd", d); end
        time_v = 40'h13_5555_0000;
        cyc();
        n_tests++; if (rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL data_o hold got %h exp 0000abcd", rdata); end
        addr = A_TIME_HI; re = 1'b1;
        #2;
        n_tests++; if (rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL data_o early got %h exp 0000abcd", rdata); end
        @(posedge clk);
        #1;
        re = 1'b0;
        n_tests++; if (rdata !== 32'h0000_0012) begin n_fail++; $display("FAIL TIME_HI got %h exp 00000012", rdata); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        set_cmp(40'd0);
        time_v = 40'd5;
        wr(A_CTRL, 32'h5);
        cyc();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL areset pre irq got %b exp 1", irq); end
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL areset pre STATUS got %h exp 1", d); end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL areset irq got %b exp 0", irq); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL areset data_o got %h exp 0", rdata); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(A_STATUS, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL areset post STATUS got %h exp 0", d); end
        cyc();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL areset idle irq got %b exp 0", irq); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_shadow_commit();
        test_commit_collision();
        test_w1c_collision();
        test_period_zero();
        test_snapshot();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
